// File: rtl/alu_control_unit_if.sv
// Bundle between the main controller and the ALU control unit.
// Optional flag: ALU_CTRL_ILLEGAL_EN adds the registered illegal-code output.
interface alu_control_unit_if;
    logic       en;
    logic [1:0] aluControlOp;
    logic [3:0] functionCode;
    logic [2:0] aluOp;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       illegal;

    modport master (output en, aluControlOp, functionCode, input aluOp, illegal);
    modport slave  (input en, aluControlOp, functionCode, output aluOp, illegal);
`else
    modport master (output en, aluControlOp, functionCode, input aluOp);
    modport slave  (input en, aluControlOp, functionCode, output aluOp);
`endif
endinterface

// File: rtl/alu_control_unit.sv
// Decodes controller class + function code into a registered 3-bit ALU select.
// Optional flag: ALU_CTRL_ILLEGAL_EN adds a registered flag for undefined codes.
module alu_control_unit (
    input  logic              clk,
    input  logic              reset,
    alu_control_unit_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_ROL = 3'b110,
        OP_ROR = 3'b111
    } alu_op_t;

    alu_op_t nextOp;
    logic    nextIllegal;

    // Register and immediate classes share one table; undefined codes fall back to ADD.
    always_comb begin
        nextOp      = OP_ADD;
        nextIllegal = 1'b0;
        unique case (bus.aluControlOp)
            2'b01: nextOp = OP_ADD;
            2'b10: nextOp = OP_SUB;
            default: begin
                unique case (bus.functionCode)
                    4'b0001: nextOp = OP_ADD;
                    4'b0010: nextOp = OP_SUB;
                    4'b0100: nextOp = OP_AND;
                    4'b1000: nextOp = OP_OR;
                    4'b0101: nextOp = OP_SHL;
                    4'b0110: nextOp = OP_SHR;
                    4'b1001: nextOp = OP_ROL;
                    4'b1010: nextOp = OP_ROR;
                    default: begin
                        nextOp      = OP_ADD;
                        nextIllegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.aluOp <= OP_ADD;
        end else if (bus.en) begin
            bus.aluOp <= nextOp;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.illegal <= 1'b0;
        end else if (bus.en) begin
            bus.illegal <= nextIllegal;
        end
    end
`else
    logic unusedIllegal;
    assign unusedIllegal = nextIllegal;
`endif

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: directed plan followed by randomized steps vs. a table model.
// Define ALU_CTRL_ILLEGAL_EN for both RTL and bench to also check the illegal flag.
module tb_alu_control_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   fcTable [16];
    logic [2:0] expAluOp;
    logic       expIllegal;

    alu_control_unit_if bus ();

    alu_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: class 01 is always ADD, class 10 always SUB, others look up the table.
    function automatic int modelOp(input int op, input int fc);
        if (op == 1) return 0;
        if (op == 2) return 1;
        if (fcTable[fc] < 0) return 0;
        return fcTable[fc];
    endfunction

    function automatic bit modelIllegal(input int op, input int fc);
        return ((op == 0) || (op == 3)) && (fcTable[fc] < 0);
    endfunction

    task automatic checkOutput(input string tag);
        checks++;
        assert (bus.aluOp === expAluOp) else begin
            errors++;
            $error("[TB] FAIL %s: aluOp observed %b expected %b", tag, bus.aluOp, expAluOp);
        end
`ifdef ALU_CTRL_ILLEGAL_EN
        checks++;
        assert (bus.illegal === expIllegal) else begin
            errors++;
            $error("[TB] FAIL %s_illegal: illegal observed %b expected %b", tag, bus.illegal, expIllegal);
        end
`endif
    endtask

    // Drive away from the edge, update the model at the edge, sample 1 time unit later.
    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] op,
                                 input logic [3:0] fc, input string tag);
        @(negedge clk);
        reset            = rst;
        bus.en           = en;
        bus.aluControlOp = op;
        bus.functionCode = fc;
        @(posedge clk);
        if (rst) begin
            expAluOp   = 3'b000;
            expIllegal = 1'b0;
        end else if (en) begin
            expAluOp   = 3'(modelOp(int'(op), int'(fc)));
            expIllegal = modelIllegal(int'(op), int'(fc));
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) fcTable[i] = -1;
        fcTable[4'b0001] = 0;
        fcTable[4'b0010] = 1;
        fcTable[4'b0100] = 2;
        fcTable[4'b1000] = 3;
        fcTable[4'b0101] = 4;
        fcTable[4'b0110] = 5;
        fcTable[4'b1001] = 6;
        fcTable[4'b1010] = 7;
        expAluOp         = 3'b000;
        expIllegal       = 1'b0;
        reset            = 1'b1;
        bus.en           = 1'b1;
        bus.aluControlOp = 2'b11;
        bus.functionCode = 4'b1010;

        applyStimulus(1'b1, 1'b1, 2'b11, 4'b1010, "reset");
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b0010, "first_sub");

        applyStimulus(1'b0, 1'b1, 2'b00, 4'b0001, "rtype_add");
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b0010, "rtype_sub");
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b0100, "rtype_and");
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b1000, "rtype_or");

        applyStimulus(1'b0, 1'b1, 2'b01, 4'b0101, "ldst_add");
        applyStimulus(1'b0, 1'b1, 2'b10, 4'b0001, "branch_sub");

        applyStimulus(1'b0, 1'b1, 2'b11, 4'b0100, "itype_and");
        applyStimulus(1'b0, 1'b1, 2'b11, 4'b1010, "itype_ror");

        applyStimulus(1'b0, 1'b1, 2'b00, 4'b1000, "stall_setup");
        applyStimulus(1'b0, 1'b0, 2'b00, 4'b0110, "stall_hold");
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b0110, "stall_release");
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b1111, "undefined_code");

        applyStimulus(1'b0, 1'b1, 2'b11, 4'b1010, "prio_setup");
        applyStimulus(1'b1, 1'b0, 2'b11, 4'b1010, "reset_priority");

        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                          2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)),
                          "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Decodes the 2-bit ALU control class from the main controller and the 4-bit instruction function code into the 3-bit ALU operation select.
- Sits between the main control unit and the ALU in the datapath.
- Output is registered: one clock of latency, with a synchronous active-high reset.

Parameters:
- None. All widths are fixed: class 2 bits, function code 4 bits, ALU operation 3 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  update enable; when low, the registered outputs hold (pipeline stall)
- aluControlOp  input  2  operation class from the main controller
- functionCode  input  4  instruction function field
- aluOp  output  3  registered ALU operation select

ALU operation encoding (aluOp):
- 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR, 110 ROL, 111 ROR

Behaviour:
- On a rising clk edge with reset=1: aluOp <= 000. Reset takes priority over en.
- On a rising clk edge with reset=0 and en=1: aluOp <= decode(aluControlOp, functionCode).
- On a rising clk edge with reset=0 and en=0: aluOp holds its value.
- Latency: inputs present before edge N appear on aluOp after edge N. The decode itself is purely combinational.
- Decode for aluControlOp=00 (register-type) and aluControlOp=11 (immediate-type) uses the same function-code table:
  - 0001 ADD 000
  - 0010 SUB 001
  - 0100 AND 010
  - 1000 OR 011
  - 0101 SHL 100
  - 0110 SHR 101
  - 1001 ROL 110
  - 1010 ROR 111
  - Any other code (0000, 0011, 0111, 1011-1111) is undefined and decodes to 000 (ADD).
- aluControlOp=01 (load/store address): ADD 000; functionCode is ignored.
- aluControlOp=10 (branch compare): SUB 001; functionCode is ignored.
- X or Z on an input: no requirement.
- Reset asserted mid-operation: aluOp is 000 after the next edge, regardless of en or the inputs.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_EN.
- When defined, an extra port is added: illegal  output  1.
  - It is registered alongside aluOp and shares the same reset/en rules; its reset value is 0.
  - It is set to 1 when aluControlOp is 00 or 11 and functionCode is an undefined code; otherwise it is 0.
  - aluOp still decodes to 000 in the illegal case.
- When not defined, the port and its register are absent; behaviour is otherwise identical.

Test Plan:
- Reset: reset=1 with any inputs for one edge -> aluOp=000 (and illegal=0 if the feature is enabled). Then reset=0, en=1, op=00, fc=0010 -> aluOp=001 after the next edge.
- Register-type sweep: op=00 with fc=0001, 0010, 0100, 1000 on successive edges -> aluOp=000, 001, 010, 011, each one edge late.
- Forced classes: op=01, fc=0101 -> aluOp=000; op=10, fc=0001 -> aluOp=001.
- Immediate class: op=11, fc=0100 -> aluOp=010; op=11, fc=1010 -> aluOp=111.
- Stall and undefined code: set aluOp=011, then en=0 and change to op=00, fc=0110 -> aluOp stays 011; en=1 -> 101. Then op=00, fc=1111 -> aluOp=000, illegal=1 when the feature is enabled.
- Reset priority: en=0 and reset=1 while aluOp=111 -> aluOp=000 after the edge.
